// File: rtl/sequential_divider.sv
// Multi-cycle signed divider: restoring shift-subtract on operand magnitudes,
// then one sign-fixup cycle. Quotient goes to LO, remainder to HI.
module sequential_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient_lo,
    output logic [WIDTH-1:0] remainder_hi,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               flag_q, flag_d;

    logic [WIDTH-1:0]   abs_dividend_c;
    logic [WIDTH-1:0]   abs_divisor_c;
    logic [WIDTH:0]     shifted_c;
    logic [WIDTH:0]     diff_c;

    // Magnitudes are unsigned WIDTH bits, so the most-negative value maps onto itself.
    assign abs_dividend_c = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign abs_divisor_c  = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;

    // One restoring step: bring in the next dividend bit and trial-subtract.
    assign shifted_c = {rem_q, quo_q[WIDTH-1]};
    assign diff_c    = shifted_c - {1'b0, dvsr_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dbz_d       = dbz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        flag_d      = flag_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    flag_d    = 1'b0;
                    neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_rem_d = dividend[WIDTH-1];
                    cnt_d     = '0;
                    rem_d     = '0;
                    dvsr_d    = abs_divisor_c;
                    if (divisor == '0) begin
                        // Keep the raw dividend; it is returned as the remainder.
                        dbz_d   = 1'b1;
                        quo_d   = dividend;
                        state_d = FIXUP;
                    end else begin
                        dbz_d   = 1'b0;
                        quo_d   = abs_dividend_c;
                        state_d = DIVIDE;
                    end
                end
            end

            DIVIDE: begin
                if (!diff_c[WIDTH]) begin
                    rem_d = diff_c[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted_c[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end

            FIXUP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = quo_q;
                    flag_d      = 1'b1;
                end else begin
                    quotient_d  = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
                    remainder_d = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            flag_q      <= flag_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign quotient_lo  = quotient_q;
    assign remainder_hi = remainder_q;
    assign div_by_zero  = flag_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider against a plain signed-arithmetic model.
module tb_sequential_divider;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient_lo;
    logic [31:0] remainder_hi;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sequential_divider #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient_lo (quotient_lo),
        .remainder_hi(remainder_hi),
        .div_by_zero (div_by_zero)
    );

    // Reference: {flag, quotient, remainder} from truncating signed division.
    function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        z = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end
        return {z, q, r};
    endfunction

    // Drive a one-cycle start, then scramble the operand bus.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // From the negedge after acceptance, count cycles until done (bounded).
    task automatic wait_done(output int lat, output logic busy_ok, output logic held_ok);
        logic [31:0] q0;
        logic [31:0] r0;
        q0      = quotient_lo;
        r0      = remainder_hi;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        lat     = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (quotient_lo !== q0 || remainder_hi !== r0) held_ok = 1'b0;
            @(negedge clock);
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset;
        clear = 1'b0;
        start = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #12;
        total++;
        if ({busy, done, quotient_lo, remainder_hi, div_by_zero} !== 67'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, done, quotient_lo, remainder_hi, div_by_zero});
        end
        @(negedge clock);
        clear = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        logic bok, hok;
        launch(32'd40, 32'd4);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_done(lat, bok, hok);
        total++;
        if (lat !== 33) begin bad++; $display("FAIL basic_latency: got %0d want 33", lat); end
        total++;
        if (bok !== 1'b1) begin bad++; $display("FAIL basic_busy_window: got %b want 1", bok); end
        total++;
        if ({quotient_lo, remainder_hi, div_by_zero} !== {32'd10, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL basic_result: got %h %h %b want 0000000a 00000000 0",
                     quotient_lo, remainder_hi, div_by_zero);
        end
        @(negedge clock);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_signs;
        logic [31:0] as [0:5];
        logic [31:0] bs [0:5];
        logic [64:0] exp;
        int lat;
        logic bok, hok;
        as = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'd5};
        bs = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd9};
        for (int i = 0; i < 6; i++) begin
            exp = ref_div(as[i], bs[i]);
            launch(as[i], bs[i]);
            wait_done(lat, bok, hok);
            total++;
            if (lat !== 33 || bok !== 1'b1) begin
                bad++;
                $display("FAIL signs_timing[%0d]: got lat=%0d busy_ok=%b want 33 1", i, lat, bok);
            end
            total++;
            if ({div_by_zero, quotient_lo, remainder_hi} !== exp) begin
                bad++;
                $display("FAIL signs_result[%0d]: got %b %h %h want %b %h %h", i,
                         div_by_zero, quotient_lo, remainder_hi, exp[64], exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_div_by_zero;
        int lat;
        logic bok, hok;
        launch(32'd100, 32'd0);
        wait_done(lat, bok, hok);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL dbz_latency: got %0d want 1", lat); end
        total++;
        if ({quotient_lo, remainder_hi, div_by_zero} !== {32'hFFFF_FFFF, 32'd100, 1'b1}) begin
            bad++;
            $display("FAIL dbz_result: got %h %h %b want ffffffff 00000064 1",
                     quotient_lo, remainder_hi, div_by_zero);
        end
        repeat (3) @(negedge clock);
        total++;
        if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_hold: got %b want 1", div_by_zero); end
        launch(32'd9, 32'd3);
        wait_done(lat, bok, hok);
        total++;
        if ({quotient_lo, remainder_hi, div_by_zero} !== {32'd3, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL dbz_clear: got %h %h %b want 00000003 00000000 0",
                     quotient_lo, remainder_hi, div_by_zero);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic [64:0] exp;
        int lat;
        logic bok, hok;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = -32'($urandom_range(1, 15));
                2:       b = 32'd0;
                3:       b = {16'd0, 16'($urandom)};
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            exp = ref_div(a, b);
            launch(a, b);
            wait_done(lat, bok, hok);
            total++;
            if (lat !== (exp[64] ? 1 : 33) || bok !== 1'b1 || hok !== 1'b1) begin
                bad++;
                $display("FAIL rand_timing[%0d]: got lat=%0d busy_ok=%b held_ok=%b want %0d 1 1",
                         i, lat, bok, hok, exp[64] ? 1 : 33);
            end
            total++;
            if ({div_by_zero, quotient_lo, remainder_hi} !== exp) begin
                bad++;
                $display("FAIL rand_result[%0d] %h/%h: got %b %h %h want %b %h %h", i, a, b,
                         div_by_zero, quotient_lo, remainder_hi, exp[64], exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic bok, hok;
        @(negedge clock);
        dividend = 32'd1000;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clock);
        dividend = 32'd5;
        divisor  = 32'd5;
        wait_done(lat, bok, hok);
        total++;
        if (lat !== 33 || bok !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_timing: got lat=%0d busy_ok=%b want 33 1", lat, bok);
        end
        total++;
        if ({quotient_lo, remainder_hi, div_by_zero} !== {32'd142, 32'd6, 1'b0}) begin
            bad++;
            $display("FAIL b2b_first_result: got %h %h %b want 0000008e 00000006 0",
                     quotient_lo, remainder_hi, div_by_zero);
        end
        @(negedge clock);
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: got done=%b busy=%b want 0 1", done, busy);
        end
        wait_done(lat, bok, hok);
        total++;
        if (lat !== 33 || hok !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_timing: got lat=%0d held_ok=%b want 33 1", lat, hok);
        end
        total++;
        if ({quotient_lo, remainder_hi, div_by_zero} !== {32'd1, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL b2b_second_result: got %h %h %b want 00000001 00000000 0",
                     quotient_lo, remainder_hi, div_by_zero);
        end
    endtask

    task automatic test_async_clear;
        int lat;
        int seen;
        logic bok, hok;
        launch(32'd123456, 32'd10);
        repeat (15) @(negedge clock);
        #2;
        clear = 1'b0;
        #1;
        total++;
        if ({busy, done, quotient_lo, remainder_hi, div_by_zero} !== 67'd0) begin
            bad++;
            $display("FAIL clear_outputs: got %h want 0",
                     {busy, done, quotient_lo, remainder_hi, div_by_zero});
        end
        repeat (2) @(negedge clock);
        clear = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL clear_no_done: got %0d want 0", seen); end
        launch(32'd6, 32'd4);
        wait_done(lat, bok, hok);
        total++;
        if (lat !== 33 || {quotient_lo, remainder_hi, div_by_zero} !== {32'd1, 32'd2, 1'b0}) begin
            bad++;
            $display("FAIL clear_recover: got lat=%0d %h %h %b want 33 00000001 00000002 0",
                     lat, quotient_lo, remainder_hi, div_by_zero);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_by_zero();
        test_random();
        test_back_to_back();
        test_async_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
